parity_frame_scheduler: RTL and testbench
=========================================

PARITY_FRAME_SCHEDULER -- requirements
Module: parity_frame_scheduler

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; SHALL be at least 2.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a word pending.
REQ-005 req0_data  input  WIDTH  requester 0 word; sampled only on handshake.
REQ-006 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-007 req1_valid  input  1  requester 1 has a word pending.
REQ-008 req1_data  input  WIDTH  requester 1 word; sampled only on handshake.
REQ-009 req1_ready  output  1  requester 1 word accepted this cycle.
REQ-010 ser_bit  output  1  serialized data bit, LSB first.
REQ-011 ser_valid  output  1  ser_bit is valid this cycle.
REQ-012 ser_last  output  1  marks the final bit of a word.
REQ-013 done  output  1  one-cycle pulse: parity result valid.
REQ-014 done_id  output  1  requester index of the completed word.
REQ-015 done_parity  output  1  XOR of all word bits; 1 means an odd count of ones.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, SHIFT and DONE; the state register SHALL be 2 bits.
REQ-018 Handshake rule: a word transfers in any cycle where valid and ready are both high; readyN SHALL be combinational from state, valids and last_grant.
REQ-019 In IDLE the grant rules SHALL be:
- only one valid: grant that requester.
- both valid: grant the requester other than last_grant (round-robin).
- neither valid: no grant.
REQ-020 readyN SHALL be high only in IDLE and only for the granted requester; at most one ready SHALL be high in any cycle.
REQ-021 On a grant, the FSM SHALL do all of the following:
- load the shift register with the data.
- clear the parity accumulator.
- load the bit counter with WIDTH-1.
- record the requester id and set last_grant to it.
- move to SHIFT.
REQ-022 In SHIFT, ser_valid=1 and ser_bit=shreg[0]; each cycle:
- shift right by one.
- XOR ser_bit into the parity accumulator.
- decrement the counter.
REQ-023 ser_last SHALL be high in SHIFT when the counter equals 0; the next state SHALL then be DONE.
REQ-024 In DONE, done=1 for exactly one cycle, with done_id and done_parity valid; next state SHALL be IDLE.
REQ-025 Timing:
- handshake in cycle t.
- bits on cycles t+1 .. t+WIDTH.
- done on cycle t+WIDTH+1.
- earliest next handshake on cycle t+WIDTH+2.
REQ-026 Request changes during SHIFT or DONE SHALL have no effect on the word in flight.
REQ-027 Outside SHIFT, ser_bit, ser_valid and ser_last SHALL be 0; outside DONE, done SHALL be 0.
REQ-028 done_id and done_parity SHALL hold their last values outside DONE.

Reset
REQ-029 On reset, all of the following SHALL hold:
- state=IDLE, counter=0, shift register=0, parity accumulator=0.
- last_grant=1, so requester 0 wins the first tie.
- done_id=0, done_parity=0.
- all strobes low, busy=0.
REQ-030 Reset asserted in SHIFT or DONE SHALL abort the word with no done pulse; the next cycle after reset deasserts SHALL be IDLE.
REQ-031 Reset SHALL take priority over any simultaneous handshake; readyN SHALL be 0 while reset is high.

Verification (WIDTH=8)
REQ-032 After reset, req0_valid=1, req0_data=8'hA5 -> req0_ready pulses once; ser_bit sequence 1,0,1,0,0,1,0,1 with ser_last on the 8th bit; done=1, done_id=0, done_parity=0 on the 9th cycle after the handshake.
REQ-033 req1_valid=1, req1_data=8'h07 only -> done_id=1, done_parity=1.
REQ-034 Both valid at the same time after reset (req0=8'h01, req1=8'h03) -> req0 is served first (done_parity=1), then req1 (done_parity=0); handshakes are 10 cycles apart.
REQ-035 Both valid continuously for 4 words -> grant order is 0,1,0,1 and readies are never high together.
REQ-036 Reset asserted at the 4th ser_bit of 8'hFF -> no done pulse; busy=0 after reset; a new word is accepted normally and yields done_parity=0.
REQ-037 No requests for 20 cycles -> busy, ser_valid and done all stay 0.

Source files
------------

// File: rtl/parity_frame_scheduler.sv
// Round-robin arbiter between two requesters that serializes the granted word
// LSB first and reports its parity with a one-cycle done pulse.
module parity_frame_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid_i,
    input  logic [WIDTH-1:0] req0_data_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [WIDTH-1:0] req1_data_i,
    output logic             req1_ready_o,
    output logic             ser_bit_o,
    output logic             ser_valid_o,
    output logic             ser_last_o,
    output logic             done_o,
    output logic             done_id_o,
    output logic             done_parity_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             par_q;
    logic             id_q;
    logic             last_grant_q;
    logic             done_id_q;
    logic             done_parity_q;
    logic             ser_bit_q;
    logic             ser_valid_q;
    logic             ser_last_q;
    logic             done_q;
    logic             busy_q;

    logic             grant0_s;
    logic             grant1_s;
    logic [WIDTH-1:0] grant_data_s;

    // Fold one serialized bit into the running parity.
    function automatic logic parity_step(input logic acc, input logic b);
        return acc ^ b;
    endfunction

    // Grant selection: only in IDLE, never under reset, round-robin on a tie.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (reset || (state_q != IDLE)) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0_valid_i && req1_valid_i) begin
            if (last_grant_q) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (req0_valid_i) begin
            grant0_s = 1'b1;
        end else if (req1_valid_i) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Data mux for the granted requester.
    always_comb begin
        grant_data_s = {WIDTH{1'b0}};
        if (grant1_s) begin
            grant_data_s = req1_data_i;
        end else begin
            grant_data_s = req0_data_i;
        end
    end

    // Main FSM; strobes are registered so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= {WIDTH{1'b0}};
            cnt_q         <= CNT_ZERO;
            par_q         <= 1'b0;
            id_q          <= 1'b0;
            last_grant_q  <= 1'b1;
            done_id_q     <= 1'b0;
            done_parity_q <= 1'b0;
            ser_bit_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            ser_last_q    <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0_s || grant1_s) begin
                        shreg_q      <= grant_data_s;
                        par_q        <= 1'b0;
                        cnt_q        <= CNT_LOAD;
                        id_q         <= grant1_s;
                        last_grant_q <= grant1_s;
                        state_q      <= SHIFT;
                        ser_valid_q  <= 1'b1;
                        ser_bit_q    <= grant_data_s[0];
                        ser_last_q   <= 1'b0;
                        busy_q       <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    shreg_q <= shreg_q >> 1;
                    par_q   <= parity_step(par_q, shreg_q[0]);
                    if (cnt_q == CNT_ZERO) begin
                        state_q       <= DONE;
                        ser_valid_q   <= 1'b0;
                        ser_bit_q     <= 1'b0;
                        ser_last_q    <= 1'b0;
                        done_q        <= 1'b1;
                        done_id_q     <= id_q;
                        done_parity_q <= parity_step(par_q, shreg_q[0]);
                    end else begin
                        // Preload the strobes for the next bit while shifting.
                        cnt_q      <= cnt_q - CNT_ONE;
                        ser_bit_q  <= shreg_q[1];
                        ser_last_q <= (cnt_q == CNT_ONE);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    ser_valid_q <= 1'b0;
                    ser_bit_q   <= 1'b0;
                    ser_last_q  <= 1'b0;
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready_o  = grant0_s;
    assign req1_ready_o  = grant1_s;
    assign ser_bit_o     = ser_bit_q;
    assign ser_valid_o   = ser_valid_q;
    assign ser_last_o    = ser_last_q;
    assign done_o        = done_q;
    assign done_id_o     = done_id_q;
    assign done_parity_o = done_parity_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_parity_frame_scheduler.sv
// Directed bench for parity_frame_scheduler: a cycle-timeline model predicts every
// output each cycle, and literal checks pin the model on the listed scenarios.
module tb_parity_frame_scheduler;

    localparam int W    = 8;
    localparam int MAXC = 4000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         v0 = 1'b0;
    logic         v1 = 1'b0;
    logic [W-1:0] d0 = '0;
    logic [W-1:0] d1 = '0;
    logic r0, r1, sb, sv, sl, dn, did, dpar, bsy;

    parity_frame_scheduler #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(r0),
        .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(r1),
        .ser_bit_o(sb), .ser_valid_o(sv), .ser_last_o(sl),
        .done_o(dn), .done_id_o(did), .done_parity_o(dpar), .busy_o(bsy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Timeline model: expected outputs per absolute cycle number.
    bit e_sv [MAXC];
    bit e_sb [MAXC];
    bit e_sl [MAXC];
    bit e_dn [MAXC];
    bit e_did[MAXC];
    bit e_dp [MAXC];
    bit e_bsy[MAXC];
    int free_at = 0;
    bit m_last  = 1'b1;
    bit hold_id = 1'b0;
    bit hold_par = 1'b0;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic schedule(input int t, input bit id, input logic [W-1:0] d);
        bit p;
        p = 1'b0;
        for (int k = 1; k <= W; k++) begin
            e_sv[t+k]  = 1'b1;
            e_sb[t+k]  = d[k-1];
            e_sl[t+k]  = (k == W);
            e_bsy[t+k] = 1'b1;
            p = p ^ d[k-1];
        end
        e_dn[t+W+1]  = 1'b1;
        e_did[t+W+1] = id;
        e_dp[t+W+1]  = p;
        e_bsy[t+W+1] = 1'b1;
    endtask

    // Compare process: predict this cycle's outputs, check them, then advance the model.
    always @(negedge clk) begin
        bit x0, x1;
        if (chk_en && (cyc + W + 2 < MAXC)) begin
            x0 = 1'b0;
            x1 = 1'b0;
            if (!reset && cyc >= free_at) begin
                if (v0 && (!v1 || m_last)) x0 = 1'b1;
                else if (v1) x1 = 1'b1;
            end
            if (e_dn[cyc]) begin
                hold_id  = e_did[cyc];
                hold_par = e_dp[cyc];
            end
            chk("req0_ready", r0, x0);
            chk("req1_ready", r1, x1);
            chk("ser_valid", sv, e_sv[cyc]);
            chk("ser_bit", sb, e_sb[cyc]);
            chk("ser_last", sl, e_sl[cyc]);
            chk("done", dn, e_dn[cyc]);
            chk("done_id", did, hold_id);
            chk("done_parity", dpar, hold_par);
            chk("busy", bsy, e_bsy[cyc]);
            if (x0) begin
                schedule(cyc, 1'b0, d0);
                m_last = 1'b0;
                free_at = cyc + W + 2;
            end else if (x1) begin
                schedule(cyc, 1'b1, d1);
                m_last = 1'b1;
                free_at = cyc + W + 2;
            end
            if (reset) begin
                for (int i = cyc + 1; i <= cyc + W + 2; i++) begin
                    e_sv[i] = 0; e_sb[i] = 0; e_sl[i] = 0; e_dn[i] = 0;
                    e_did[i] = 0; e_dp[i] = 0; e_bsy[i] = 0;
                end
                free_at  = cyc + 1;
                m_last   = 1'b1;
                hold_id  = 1'b0;
                hold_par = 1'b0;
            end
        end
    end

    // Observation logs used by the literal checks.
    int hs_cyc[$];
    int hs_id[$];
    int dn_cyc[$];
    int dn_id[$];
    int dn_par[$];
    int words[$];
    int last_pos[$];
    logic [W-1:0] cap = '0;
    int nbits = 0;
    int sv_seen = 0;
    int bsy_seen = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (r0 === 1'b1 && v0) begin hs_cyc.push_back(cyc); hs_id.push_back(0); end
            if (r1 === 1'b1 && v1) begin hs_cyc.push_back(cyc); hs_id.push_back(1); end
            if (sv === 1'b1) begin
                sv_seen++;
                cap = {sb, cap[W-1:1]};
                nbits++;
                if (sl === 1'b1) begin
                    words.push_back(int'(cap));
                    last_pos.push_back(nbits);
                    nbits = 0;
                end
            end
            if (dn === 1'b1) begin
                dn_cyc.push_back(cyc);
                dn_id.push_back(int'(did));
                dn_par.push_back(int'(dpar));
            end
            if (bsy === 1'b1) bsy_seen++;
            if (reset) nbits = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_hs(input int n, input int budget);
        int k;
        k = 0;
        while (hs_cyc.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk_int("handshake_within_budget", hs_cyc.size() >= n ? 1 : 0, 1);
    endtask

    task automatic send(input bit id, input logic [W-1:0] d);
        int n;
        n = hs_cyc.size() + 1;
        if (id == 1'b0) begin v0 = 1'b1; d0 = d; end
        else begin v1 = 1'b1; d1 = d; end
        wait_hs(n, 40);
        tick();
        if (id == 1'b0) begin v0 = 1'b0; d0 = W'($urandom); end
        else begin v1 = 1'b0; d1 = W'($urandom); end
    endtask

    initial begin
        int b, k, nd;
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        idle(2);
        reset = 1'b0;

        // Single word from requester 0.
        send(1'b0, 8'hA5);
        idle(12);
        chk_int("a5_id", hs_id[0], 0);
        chk_int("a5_bits", words[0], 32'hA5);
        chk_int("a5_last_pos", last_pos[0], 8);
        chk_int("a5_done_lat", dn_cyc[0] - hs_cyc[0], 9);
        chk_int("a5_done_id", dn_id[0], 0);
        chk_int("a5_parity", dn_par[0], 0);

        // Single word from requester 1.
        send(1'b1, 8'h07);
        idle(12);
        chk_int("07_done_id", dn_id[1], 1);
        chk_int("07_parity", dn_par[1], 1);

        // Tie after reset: requester 0 first.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        b = hs_cyc.size();
        k = dn_par.size();
        v0 = 1'b1; d0 = 8'h01;
        v1 = 1'b1; d1 = 8'h03;
        wait_hs(b + 1, 40);
        tick();
        v0 = 1'b0;
        wait_hs(b + 2, 40);
        tick();
        v1 = 1'b0;
        idle(12);
        chk_int("tie_first", hs_id[b], 0);
        chk_int("tie_second", hs_id[b+1], 1);
        chk_int("tie_spacing", hs_cyc[b+1] - hs_cyc[b], 10);
        chk_int("tie_par0", dn_par[k], 1);
        chk_int("tie_par1", dn_par[k+1], 0);

        // Both valid continuously for four words.
        b = hs_cyc.size();
        v0 = 1'b1; d0 = 8'h3C;
        v1 = 1'b1; d1 = 8'hC1;
        wait_hs(b + 4, 80);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        idle(12);
        chk_int("rr_0", hs_id[b], 0);
        chk_int("rr_1", hs_id[b+1], 1);
        chk_int("rr_2", hs_id[b+2], 0);
        chk_int("rr_3", hs_id[b+3], 1);

        // Reset on the 4th bit of 8'hFF aborts the word.
        b = hs_cyc.size();
        nd = dn_cyc.size();
        v0 = 1'b1; d0 = 8'hFF;
        wait_hs(b + 1, 40);
        tick();
        v0 = 1'b0;
        idle(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", bsy, 1'b0);
        idle(12);
        chk_int("abort_no_done", dn_cyc.size(), nd);
        send(1'b0, 8'h5A);
        idle(12);
        chk_int("after_abort_done", dn_cyc.size(), nd + 1);
        chk_int("after_abort_par", dn_par[nd], 0);
        chk_int("after_abort_bits", words[words.size()-1], 32'h5A);

        // Quiet period.
        nd = dn_cyc.size();
        k = sv_seen;
        b = bsy_seen;
        idle(20);
        chk_int("quiet_done", dn_cyc.size(), nd);
        chk_int("quiet_ser_valid", sv_seen, k);
        chk_int("quiet_busy", bsy_seen, b);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
